// File: rtl/led_seq_pkg.sv
// Shared types and constants for the RGB LED pattern sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_COUNT   = 2'd3
  } mode_e;

  localparam int DUTY_W = 8;
  typedef logic [DUTY_W-1:0] duty_t;
  localparam duty_t DUTY_FULL = 8'd255;

  // Triangle ramp: rises over steps 0..127, falls over 128..255; (255-s) is ~s.
  function automatic duty_t breathe_duty(input duty_t step);
    duty_t fold;
    fold = step[DUTY_W-1] ? ~step : step;
    return {fold[DUTY_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle pulse on each accepted press (debounced 1->0 transition).
module btn_debounce
  import led_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  // The synchronizer already spent one cycle at the new level before the
  // first mismatch is counted, so acceptance happens at count D-2.
  localparam logic [CW-1:0] HOLD_LAST = CW'(DEBOUNCE_CYCLES - 2);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  always_comb begin
    db_d    = db_q;
    cnt_d   = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == HOLD_LAST) begin
        db_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    press_d = db_q & ~db_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      db_q    <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/led_sequencer.sv
// Mode-selectable RGB LED sequencer: button-driven mode FSM, step timebase,
// per-mode duty generation and an 8-bit PWM output stage.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int   CLK_HZ          = 27_000_000,
  parameter int   STEP_TICKS      = 13_500_000,
  parameter int   BREATHE_TICKS   = 105_469,
  parameter int   DEBOUNCE_CYCLES = 270_000,
  parameter logic LED_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_n,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic [1:0] mode
);

  if (CLK_HZ < 1 || STEP_TICKS < 2 || BREATHE_TICKS < 2 || DEBOUNCE_CYCLES < 2) begin : g_bad_params
    $error("led_sequencer: tick/debounce parameters must be >= 2");
  end

  localparam int MAX_TICKS = (STEP_TICKS > BREATHE_TICKS) ? STEP_TICKS : BREATHE_TICKS;
  localparam int PW        = $clog2(MAX_TICKS);
  localparam logic [PW-1:0] STEP_LAST    = PW'(STEP_TICKS - 1);
  localparam logic [PW-1:0] BREATHE_LAST = PW'(BREATHE_TICKS - 1);

  logic             press;
  mode_e            mode_q, mode_d;
  logic [PW-1:0]    presc_q, presc_d;
  duty_t            step_q, step_d;
  logic             step_tick;
  duty_t            pwm_q;
  logic [2:0][DUTY_W-1:0] duty_q, duty_nxt;
  logic [2:0]       lit, pin_q, pin_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n_i (btn_n),
    .press_o (press)
  );

  assign step_tick = (presc_q == ((mode_q == MODE_BREATHE) ? BREATHE_LAST : STEP_LAST));

  // A press restarts the timebase so every mode begins at step 0.
  always_comb begin
    mode_d  = mode_q;
    presc_d = presc_q + PW'(1);
    step_d  = step_q;
    if (press) begin
      mode_d  = mode_e'(mode_q + 2'd1);
      presc_d = '0;
      step_d  = '0;
    end else if (step_tick) begin
      presc_d = '0;
      step_d  = step_q + 8'd1;
    end
  end

  // Channel index 0 = red, 1 = green, 2 = blue.
  always_comb begin
    duty_nxt = '0;
    case (mode_q)
      MODE_CHASE: begin
        case (step_q[1:0])
          2'd0:    duty_nxt[0] = DUTY_FULL;
          2'd1:    duty_nxt[1] = DUTY_FULL;
          2'd2:    duty_nxt[2] = DUTY_FULL;
          default: duty_nxt    = '0;
        endcase
      end
      MODE_BREATHE: duty_nxt = {3{breathe_duty(step_q)}};
      MODE_COUNT: begin
        duty_nxt[0] = step_q[2] ? DUTY_FULL : '0;
        duty_nxt[1] = step_q[1] ? DUTY_FULL : '0;
        duty_nxt[2] = step_q[0] ? DUTY_FULL : '0;
      end
      default: duty_nxt = '0;
    endcase
  end

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      lit[c] = (duty_q[c] == DUTY_FULL) || (pwm_q < duty_q[c]);
    end
    pin_d = lit ^ {3{LED_ACTIVE_LOW}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_CHASE;
      presc_q <= '0;
      step_q  <= '0;
      pwm_q   <= '0;
      duty_q  <= '0;
      pin_q   <= {3{LED_ACTIVE_LOW}};
    end else begin
      mode_q  <= mode_d;
      presc_q <= presc_d;
      step_q  <= step_d;
      pwm_q   <= pwm_q + 8'd1;
      if (pwm_q == DUTY_FULL) begin
        duty_q <= duty_nxt;
      end
      pin_q   <= pin_d;
    end
  end

  assign mode  = mode_q;
  assign led_r = pin_q[0];
  assign led_g = pin_q[1];
  assign led_b = pin_q[2];

endmodule
